// File: rtl/excess3_pkg.sv
// Shared types and constants for the Excess-3 to BCD decoder.
package excess3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] X3_OFFSET   = 4'd3;
    localparam logic [3:0] X3_MIN      = 4'd3;
    localparam logic [3:0] X3_MAX      = 4'd12;
    localparam logic [3:0] BCD_INVALID = 4'hF;

endpackage

// File: rtl/excess3_digit_dec.sv
// Combinational single-digit Excess-3 decoder; illegal codes map to 4'hF with err set.
module excess3_digit_dec
    import excess3_pkg::*;
(
    input  logic [3:0] code,
    output logic [3:0] bcd,
    output logic       err
);

    logic legal;

    always_comb begin
        legal = (code >= X3_MIN) && (code <= X3_MAX);
        err   = ~legal;
        bcd   = legal ? (code - X3_OFFSET) : BCD_INVALID;
    end

endmodule

// File: rtl/excess3_to_bcd_seq.sv
// Multi-digit Excess-3 to BCD decoder, one digit per clock, MSD first.
// Define EXCESS3_BIN_EN to add the out_bin port and its binary accumulator.
//
// state | meaning
// IDLE  | in_ready=1, waiting for a word
// CONV  | decoding digit idx, counting down to digit 0
// DONE  | out_valid=1, result held until out_ready
module excess3_to_bcd_seq
    import excess3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic [DIGITS-1:0]     out_err,
`ifdef EXCESS3_BIN_EN
    output logic [$clog2(10**DIGITS)-1:0] out_bin,
`endif
    output logic                  out_any_err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
`ifdef EXCESS3_BIN_EN
    localparam int BIN_W = $clog2(10**DIGITS);
`endif

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [4*DIGITS-1:0]   data_q;
    logic [3:0]            dig_code;
    logic [3:0]            dig_bcd;
    logic                  dig_err;

    assign dig_code = data_q[{idx, 2'b00} +: 4];

    excess3_digit_dec u_dec (
        .code (dig_code),
        .bcd  (dig_bcd),
        .err  (dig_err)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            data_q      <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_bcd     <= '0;
            out_err     <= '0;
            out_any_err <= 1'b0;
`ifdef EXCESS3_BIN_EN
            out_bin     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        data_q      <= in_data;
                        idx         <= IDX_W'(DIGITS - 1);
                        out_bcd     <= '0;
                        out_err     <= '0;
                        out_any_err <= 1'b0;
`ifdef EXCESS3_BIN_EN
                        out_bin     <= '0;
`endif
                        in_ready    <= 1'b0;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    out_bcd[{idx, 2'b00} +: 4] <= dig_bcd;
                    out_err[idx]               <= dig_err;
                    out_any_err                <= out_any_err | dig_err;
`ifdef EXCESS3_BIN_EN
                    // An illegal digit anywhere zeroes the final binary value
                    if ((idx == '0) && (out_any_err || dig_err))
                        out_bin <= '0;
                    else
                        out_bin <= out_bin * BIN_W'(10) + BIN_W'(dig_bcd);
`endif
                    if (idx == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_excess3_to_bcd_seq.sv
// Directed self-checking bench for excess3_to_bcd_seq (DIGITS=4); covers out_bin when EXCESS3_BIN_EN is defined.
module tb_excess3_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bcd;
    logic [3:0]  out_err;
    logic        out_any_err;
`ifdef EXCESS3_BIN_EN
    logic [13:0] out_bin;
`endif

    int total = 0;
    int bad   = 0;
    int lat;
    logic [15:0] held_bcd;

    always #5 clk = ~clk;

    excess3_to_bcd_seq #(.DIGITS(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_err     (out_err),
`ifdef EXCESS3_BIN_EN
        .out_bin     (out_bin),
`endif
        .out_any_err (out_any_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a word for one edge; returns at the negedge following the capture edge.
    task automatic send(input logic [15:0] word);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = word;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for out_valid; lat counts cycles after the capture edge.
    task automatic wait_valid(input string tag);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, 4);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, {31'd0, out_valid}, 0);
        chk({tag, "_ready_back"}, {31'd0, in_ready}, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_bcd", {16'd0, out_bcd}, 0);
        chk("rst_out_err", {28'd0, out_err}, 0);
        chk("rst_any_err", {31'd0, out_any_err}, 0);
`ifdef EXCESS3_BIN_EN
        chk("rst_out_bin", {18'd0, out_bin}, 0);
`endif

        // Legal word
        send(16'h3456);
        chk("legal_busy", {31'd0, in_ready}, 0);
        wait_valid("legal");
        chk("legal_bcd", {16'd0, out_bcd}, 32'h0123);
        chk("legal_err", {28'd0, out_err}, 0);
        chk("legal_any", {31'd0, out_any_err}, 0);
`ifdef EXCESS3_BIN_EN
        chk("legal_bin", {18'd0, out_bin}, 123);
`endif
        consume("legal");

        // Maximum value
        send(16'hCCCC);
        wait_valid("max");
        chk("max_bcd", {16'd0, out_bcd}, 32'h9999);
        chk("max_any", {31'd0, out_any_err}, 0);
`ifdef EXCESS3_BIN_EN
        chk("max_bin", {18'd0, out_bin}, 32'h270F);
`endif
        consume("max");

        // Illegal digit, then backpressure while holding it
        send(16'h3F4A);
        wait_valid("illegal");
        chk("illegal_bcd", {16'd0, out_bcd}, 32'h0F17);
        chk("illegal_err", {28'd0, out_err}, 4'b0100);
        chk("illegal_any", {31'd0, out_any_err}, 1);
`ifdef EXCESS3_BIN_EN
        chk("illegal_bin", {18'd0, out_bin}, 0);
`endif
        held_bcd = out_bcd;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_bcd", {16'd0, out_bcd}, {16'd0, held_bcd});
            chk("bp_ready", {31'd0, in_ready}, 0);
        end
        consume("bp");

        // Error flags clear on the next capture
        send(16'h4444);
        wait_valid("clr");
        chk("clr_bcd", {16'd0, out_bcd}, 32'h1111);
        chk("clr_err", {28'd0, out_err}, 0);
        chk("clr_any", {31'd0, out_any_err}, 0);
        consume("clr");

        // Busy input is ignored during CONV and DONE
        send(16'h3456);
        in_valid = 1'b1;
        in_data  = 16'hCCCC;
        wait_valid("busy");
        in_valid = 1'b0;
        chk("busy_bcd", {16'd0, out_bcd}, 32'h0123);
        consume("busy");
        @(negedge clk);
        chk("busy_no_capture", {31'd0, in_ready}, 1);
        chk("busy_no_valid", {31'd0, out_valid}, 0);

        // Reset during the second CONV cycle
        send(16'h3456);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mrst_ready", {31'd0, in_ready}, 1);
        chk("mrst_valid", {31'd0, out_valid}, 0);
        chk("mrst_bcd", {16'd0, out_bcd}, 0);
        chk("mrst_err", {28'd0, out_err}, 0);
        chk("mrst_any", {31'd0, out_any_err}, 0);
        send(16'h4444);
        wait_valid("after_rst");
        chk("after_rst_bcd", {16'd0, out_bcd}, 32'h1111);
`ifdef EXCESS3_BIN_EN
        chk("after_rst_bin", {18'd0, out_bin}, 1111);
`endif
        consume("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
